// File: rtl/fetch_queue_if.sv
// Fetch-queue bundle: IFU enqueue side, decode dequeue side, flush and occupancy status.
// The master modport is the pipeline (IFU + decode); the slave modport is the queue itself.
interface fetch_queue_if #(
   parameter int FETCH_WIDTH     = 2,
   parameter int DECODE_WIDTH    = 2,
   parameter int DEPTH           = 8,
   parameter int INST_ADDR_WIDTH = 32
);
   localparam int DCW = $clog2(DECODE_WIDTH + 1);
   localparam int CW  = $clog2(DEPTH + 1);

   logic                                    flush;
   logic                                    enq_valid;
   logic [FETCH_WIDTH*32-1:0]               enq_instr;
   logic [INST_ADDR_WIDTH-1:0]              enq_pc;
   logic                                    enq_ready;
   logic [DECODE_WIDTH-1:0]                 deq_valid;
   logic [DECODE_WIDTH*32-1:0]              deq_instr;
   logic [DECODE_WIDTH*INST_ADDR_WIDTH-1:0] deq_pc;
   logic [DCW-1:0]                          deq_count;
   logic [CW-1:0]                           count;
   logic                                    empty;
   logic                                    full;

   modport master (
      output flush, enq_valid, enq_instr, enq_pc, deq_count,
      input  enq_ready, deq_valid, deq_instr, deq_pc, count, empty, full
   );

   modport slave (
      input  flush, enq_valid, enq_instr, enq_pc, deq_count,
      output enq_ready, deq_valid, deq_instr, deq_pc, count, empty, full
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: accepts one full fetch bundle per cycle,
// presents up to DECODE_WIDTH oldest instructions in program order, discards everything on flush.
module fetch_queue #(
   parameter int FETCH_WIDTH     = 2,
   parameter int DECODE_WIDTH    = 2,
   parameter int DEPTH           = 8,
   parameter int INST_ADDR_WIDTH = 32
) (
   input logic          clk,
   input logic          reset,
   fetch_queue_if.slave fq
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = INST_ADDR_WIDTH;

   logic [31:0]   instr_mem_r [DEPTH];
   logic [AW-1:0] pc_mem_r    [DEPTH];
   logic [PW-1:0] head_r;
   logic [PW-1:0] tail_r;
   logic [CW-1:0] count_r;

   logic          enq_ready_s;
   logic          enq_fire_s;
   logic [CW-1:0] req_s;
   logic [CW-1:0] eff_s;

   // Ready looks only at registered occupancy, so deq_count never reaches enq_ready.
   assign enq_ready_s = (count_r <= CW'(DEPTH - FETCH_WIDTH));
   assign enq_fire_s  = fq.enq_valid && enq_ready_s && !fq.flush;

   // Clamp the decode request to the output width and to current occupancy.
   always_comb begin
      req_s = CW'(fq.deq_count);
      if (req_s > CW'(DECODE_WIDTH)) begin
         req_s = CW'(DECODE_WIDTH);
      end else begin
         req_s = req_s;
      end
      if (req_s > count_r) begin
         eff_s = count_r;
      end else begin
         eff_s = req_s;
      end
   end

   // Entry storage write: each slot gets its own PC, slot 0 carries the bundle PC.
   always_ff @(posedge clk) begin
      if (enq_fire_s && reset) begin
         for (int k = 0; k < FETCH_WIDTH; k++) begin
            instr_mem_r[tail_r + PW'(k)] <= fq.enq_instr[32*k +: 32];
            pc_mem_r[tail_r + PW'(k)]    <= fq.enq_pc + AW'(4 * k);
         end
      end
   end

   // Pointer and occupancy update; reset beats flush, flush beats enqueue/dequeue.
   always_ff @(posedge clk) begin
      if (!reset) begin
         head_r  <= {PW{1'b0}};
         tail_r  <= {PW{1'b0}};
         count_r <= {CW{1'b0}};
      end else if (fq.flush) begin
         head_r  <= {PW{1'b0}};
         tail_r  <= {PW{1'b0}};
         count_r <= {CW{1'b0}};
      end else begin
         head_r  <= head_r + PW'(eff_s);
         if (enq_fire_s) begin
            tail_r <= tail_r + PW'(FETCH_WIDTH);
         end else begin
            tail_r <= tail_r;
         end
         count_r <= count_r + (enq_fire_s ? CW'(FETCH_WIDTH) : CW'(0)) - eff_s;
      end
   end

   // Oldest-first presentation; invalid slots are forced to zero.
   always_comb begin
      fq.deq_valid = {DECODE_WIDTH{1'b0}};
      fq.deq_instr = {(DECODE_WIDTH*32){1'b0}};
      fq.deq_pc    = {(DECODE_WIDTH*AW){1'b0}};
      for (int i = 0; i < DECODE_WIDTH; i++) begin
         if (count_r > CW'(i)) begin
            fq.deq_valid[i]          = 1'b1;
            fq.deq_instr[32*i +: 32] = instr_mem_r[head_r + PW'(i)];
            fq.deq_pc[AW*i +: AW]    = pc_mem_r[head_r + PW'(i)];
         end else begin
            fq.deq_valid[i]          = 1'b0;
         end
      end
   end

   assign fq.enq_ready = enq_ready_s;
   assign fq.count     = count_r;
   assign fq.empty     = (count_r == CW'(0));
   assign fq.full      = (count_r == CW'(DEPTH));

   fetch_queue_checker #(
      .DEPTH        (DEPTH),
      .DECODE_WIDTH (DECODE_WIDTH),
      .CW           (CW)
   ) u_checker (
      .clk       (clk),
      .reset     (reset),
      .count     (count_r),
      .deq_valid (fq.deq_valid)
   );
endmodule

// Occupancy bound and thermometer coding of deq_valid.
module fetch_queue_checker #(
   parameter int DEPTH        = 8,
   parameter int DECODE_WIDTH = 2,
   parameter int CW           = 4
) (
   input logic                    clk,
   input logic                    reset,
   input logic [CW-1:0]           count,
   input logic [DECODE_WIDTH-1:0] deq_valid
);
   count_bound_a: assert property (@(posedge clk) disable iff (!reset)
      count <= CW'(DEPTH));

   deq_valid_thermo_a: assert property (@(posedge clk) disable iff (!reset)
      (deq_valid & (deq_valid + DECODE_WIDTH'(1))) == DECODE_WIDTH'(0));
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stimulus pushes expected {pc, instr} into a scoreboard,
// a negedge monitor pops and compares every slot that decode actually consumes.
module tb_fetch_queue;
   localparam int FW = 2;
   localparam int DW = 2;
   localparam int DEPTH = 8;
   localparam int AW = 32;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   logic clk;
   logic reset;
   ent_t sb[$];
   int   n_checks;
   int   n_fail;

   fetch_queue_if #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(DEPTH), .INST_ADDR_WIDTH(AW)) fq ();

   fetch_queue #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(DEPTH), .INST_ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .fq    (fq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of inputs; when accept is set the bundle is expected to enter the queue.
   task automatic drive(input logic ev, input logic [31:0] pc, input logic [31:0] i0,
                        input logic [31:0] i1, input logic [1:0] dc, input logic fl,
                        input logic accept);
      ent_t e;
      fq.enq_valid = ev;
      fq.enq_pc    = pc;
      fq.enq_instr = {i1, i0};
      fq.deq_count = dc;
      fq.flush     = fl;
      if (accept) begin
         e.pc = pc;        e.instr = i0; sb.push_back(e);
         e.pc = pc + 32'd4; e.instr = i1; sb.push_back(e);
      end
      step();
   endtask

   task automatic check_state(input string tag, input int cnt, input logic emp, input logic ful,
                              input logic rdy, input logic [1:0] vld);
      check({tag, "_count"}, 32'(fq.count), 32'(cnt));
      check({tag, "_empty"}, 32'(fq.empty), 32'(emp));
      check({tag, "_full"}, 32'(fq.full), 32'(ful));
      check({tag, "_enq_ready"}, 32'(fq.enq_ready), 32'(rdy));
      check({tag, "_deq_valid"}, 32'(fq.deq_valid), 32'(vld));
   endtask

   // Monitor: compare every slot decode consumes this cycle against the scoreboard.
   always @(negedge clk) begin
      int   n;
      ent_t e;
      if (reset && !fq.flush) begin
         n = (fq.deq_count > 2'd2) ? 2 : int'(fq.deq_count);
         for (int i = 0; i < n; i++) begin
            if (fq.deq_valid[i]) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL sb_underflow: got pc 0x%08h expected no entry", fq.deq_pc[32*i +: 32]);
               end else begin
                  e = sb.pop_front();
                  check("mon_pc", fq.deq_pc[32*i +: 32], e.pc);
                  check("mon_instr", fq.deq_instr[32*i +: 32], e.instr);
               end
            end
         end
      end
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset        = 1'b0;
      fq.flush     = 1'b0;
      fq.enq_valid = 1'b1;
      fq.enq_pc    = 32'h0000_0040;
      fq.enq_instr = {32'h1111_1111, 32'h2222_2222};
      fq.deq_count = 2'd0;
      step();
      step();
      check_state("reset", 0, 1'b1, 1'b0, 1'b1, 2'b00);
      reset = 1'b1;

      // Single enqueue, then drain
      drive(1'b1, 32'h100, 32'h0050_0093, 32'h00a0_0113, 2'd0, 1'b0, 1'b1);
      fq.enq_valid = 1'b0;
      check_state("single", 2, 1'b0, 1'b0, 1'b1, 2'b11);
      check("single_pc0", fq.deq_pc[31:0], 32'h100);
      check("single_pc1", fq.deq_pc[63:32], 32'h104);
      check("single_i0", fq.deq_instr[31:0], 32'h0050_0093);
      check("single_i1", fq.deq_instr[63:32], 32'h00a0_0113);
      drive(1'b0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
      check_state("drain", 0, 1'b1, 1'b0, 1'b1, 2'b00);
      check("drain_pc0_zero", fq.deq_pc[31:0], 32'h0);

      // Fill to full, drop a fifth bundle, then free one slot pair
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 32'h200 + 32'(8 * k), 32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k), 2'd0, 1'b0, 1'b1);
      end
      check_state("full", 8, 1'b0, 1'b1, 1'b0, 2'b11);
      drive(1'b1, 32'h300, 32'hdead_0001, 32'hdead_0002, 2'd0, 1'b0, 1'b0);
      check_state("dropped", 8, 1'b0, 1'b1, 1'b0, 2'b11);
      drive(1'b0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
      check_state("after_deq", 6, 1'b0, 1'b0, 1'b1, 2'b11);
      check("after_deq_pc0", fq.deq_pc[31:0], 32'h208);
      for (int k = 0; k < 3; k++) drive(1'b0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
      check_state("fill_drained", 0, 1'b1, 1'b0, 1'b1, 2'b00);

      // Streaming through pointer wrap: occupancy holds at 2
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 32'(8 * k), 32'h3000_0000 + 32'(2 * k), 32'h3000_0001 + 32'(2 * k), 2'd2, 1'b0, 1'b1);
         check("stream_count", 32'(fq.count), 32'd2);
      end
      check("stream_last_pc0", fq.deq_pc[31:0], 32'h48);
      drive(1'b0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
      check_state("stream_end", 0, 1'b1, 1'b0, 1'b1, 2'b00);

      // Flush beats same-cycle enqueue and dequeue
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 32'h400 + 32'(8 * k), 32'h4000_0000 + 32'(k), 32'h4100_0000 + 32'(k), 2'd0, 1'b0, 1'b1);
      end
      check_state("pre_flush", 6, 1'b0, 1'b0, 1'b1, 2'b11);
      sb.delete();
      drive(1'b1, 32'h500, 32'hbad0_0001, 32'hbad0_0002, 2'd2, 1'b1, 1'b0);
      fq.flush = 1'b0;
      fq.enq_valid = 1'b0;
      check_state("flush", 0, 1'b1, 1'b0, 1'b1, 2'b00);
      drive(1'b0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
      check_state("post_flush", 0, 1'b1, 1'b0, 1'b1, 2'b00);

      // Over-dequeue clamps at occupancy
      drive(1'b1, 32'h600, 32'h6000_0000, 32'h6000_0001, 2'd0, 1'b0, 1'b0);
      sb.push_back('{pc: 32'h600, instr: 32'h6000_0000});
      sb.push_back('{pc: 32'h604, instr: 32'h6000_0001});
      drive(1'b0, 32'h0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0);
      check_state("one_left", 1, 1'b0, 1'b0, 1'b1, 2'b01);
      check("one_left_i1_zero", fq.deq_instr[63:32], 32'h0);
      drive(1'b0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
      check_state("over_deq", 0, 1'b1, 1'b0, 1'b1, 2'b00);

      // Reset mid-operation with five entries held
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 32'h700 + 32'(8 * k), 32'h7000_0000 + 32'(k), 32'h7100_0000 + 32'(k), 2'd0, 1'b0, 1'b1);
      end
      drive(1'b0, 32'h0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0);
      check_state("five", 5, 1'b0, 1'b0, 1'b1, 2'b11);
      check("five_pc0", fq.deq_pc[31:0], 32'h704);
      reset = 1'b0;
      sb.delete();
      drive(1'b1, 32'h800, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
      check_state("mid_reset", 0, 1'b1, 1'b0, 1'b1, 2'b00);
      check("mid_reset_pc0", fq.deq_pc[31:0], 32'h0);
      reset = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
      check_state("idle", 0, 1'b1, 1'b0, 1'b1, 2'b00);

      check("sb_leftover", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer directly downstream of the IFU, between fetch and decode/rename.
- Each cycle it accepts one fetch bundle of FETCH_WIDTH instructions plus the bundle PC, and stores every instruction with its own PC.
- Presents up to DECODE_WIDTH oldest instructions to decode in program order.
- Back-pressures the IFU when space is short; discards all contents on a pipeline flush (branch/jump redirect).

Parameters:
- FETCH_WIDTH, 2, instructions per enqueue bundle (matches `FETCH_WIDTH).
- DECODE_WIDTH, 2, maximum instructions presented to and consumed by decode per cycle.
- DEPTH, 8, entry count; power of 2; DEPTH >= FETCH_WIDTH and DEPTH >= DECODE_WIDTH.
- INST_ADDR_WIDTH, 32, PC width (matches `INST_ADDR_WIDTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- flush  in  1  discard all entries (redirect).
- enq_valid  in  1  IFU bundle valid.
- enq_instr  in  FETCH_WIDTH*32  bundle; slot k at bits [32k+31:32k].
- enq_pc  in  INST_ADDR_WIDTH  PC of slot 0.
- enq_ready  out  1  queue can accept a full bundle.
- deq_valid  out  DECODE_WIDTH  bit i set if output slot i holds a valid instruction.
- deq_instr  out  DECODE_WIDTH*32  oldest-first instructions.
- deq_pc  out  DECODE_WIDTH*INST_ADDR_WIDTH  PCs of deq_instr slots.
- deq_count  in  $clog2(DECODE_WIDTH+1)  number of slots decode consumes this cycle.
- count  out  $clog2(DEPTH+1)  current occupancy.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

Behaviour:
- State: DEPTH entries {instr[31:0], pc}, head pointer, tail pointer, count register. Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH naturally.
- Reset (reset==0 at clk edge): head=tail=count=0. Resulting outputs: enq_ready=1, empty=1, full=0, deq_valid=0. Entry storage is not reset. Reset dominates flush, enqueue and dequeue.
- enq_ready = (count <= DEPTH-FETCH_WIDTH). Uses registered count only; same-cycle dequeues are not credited, so there is no combinational path from deq_count.
- Enqueue fires when enq_valid && enq_ready && !flush. Slot k is written at tail+k with instr slot k and pc = enq_pc + 4*k (modulo 2^INST_ADDR_WIDTH). tail advances by FETCH_WIDTH. Partial bundles are not supported.
- enq_valid while enq_ready==0: ignored, no state change. The IFU must hold the bundle.
- Dequeue presentation is combinational from registered state:
  - deq_valid[i] = (count > i).
  - deq_instr[i] and deq_pc[i] come from entry head+i; they are driven to 0 when deq_valid[i]==0.
- Dequeue: effective = min(deq_count, count). head advances by effective. Values above DECODE_WIDTH or above occupancy are clamped; no underflow.
- Same cycle enqueue + dequeue: count_next = count + (enq fire ? FETCH_WIDTH : 0) - effective.
- Enqueue-to-output latency: 1 cycle. An entry written at edge N is visible on deq outputs after edge N. There is no bypass while empty.
- Flush: next edge sets head=tail=count=0 and ignores same-cycle enq/deq. Outputs are empty on the following cycle.
- Order: entries leave strictly in arrival order across pointer wrap.
- Assertions:
  - count never exceeds DEPTH.
  - deq_valid is thermometer-coded (bit i set implies all lower bits set).

Test Plan (FETCH_WIDTH=2, DECODE_WIDTH=2, DEPTH=8):
- Reset: hold reset=0 for 2 cycles with enq_valid=1 -> count=0, empty=1, full=0, enq_ready=1, deq_valid=2'b00.
- Single enqueue: enq_pc=0x100, instr {0x00500093, 0x00a00113}, deq_count=0 -> next cycle count=2, deq_valid=2'b11, deq_pc={0x100, 0x104}, deq_instr in order.
- Fill/backpressure: 4 bundles with deq_count=0 -> count=8, full=1, enq_ready=0. A 5th enq_valid is dropped and count stays 8. One cycle with deq_count=2 -> count=6, enq_ready=1.
- Streaming with wrap: 10 consecutive cycles of enq (PCs 0x0, 0x8, 0x10, ...) with deq_count=2 -> count stays 2. deq_pc sequence is 0x0, 0x4, 0x8, ... contiguous with no gaps through pointer wrap.
- Flush priority: count=6, flush=1 with enq_valid=1 and deq_count=2 in the same cycle -> next cycle count=0, empty=1. The flushed bundle never appears.
- Over-dequeue and reset mid-operation: count=1 with deq_count=2 -> count=0, no underflow. Then count=5 with reset=0 for one cycle -> all reset values restored.
